// File: rtl/cvp_pkg.sv
// Shared definitions for the CVP vector processor: opcode encodings and the
// default datapath widths used by the fetch unit and the decoder.
package cvp_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INST_W = 16;

  typedef enum logic [3:0] {
    OP_VADD = 4'b0000,
    OP_VSUB = 4'b0001,
    OP_VMUL = 4'b0010,
    OP_VDOT = 4'b0011,
    OP_VLD  = 4'b0100,
    OP_VST  = 4'b0101,
    OP_VMOV = 4'b0110,
    OP_NOP  = 4'b0111,
    OP_J    = 4'b1000
  } opcode_e;

  // The opcode sits in the top nibble of every instruction word
  function automatic opcode_e getOpcode(input logic [DEF_INST_W-1:0] inst);
    return opcode_e'(inst[DEF_INST_W-1 -: 4]);
  endfunction

endpackage

// File: rtl/cvp_inst_fifo.sv
// Small instruction queue holding {inst, pc} entries between memory return
// and the decoder. Flush empties it in one cycle; push and pop may coincide
// even when full, because the pop frees the slot being written.
module cvp_inst_fifo
  import cvp_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = DEF_INST_W + DEF_ADDR_W
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [DATA_W-1:0]            i_data,
  output logic [DATA_W-1:0]            o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_full;
  logic              w_doPush;
  logic              w_doPop;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  assign o_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~w_full | w_doPop);
  assign o_data   = r_mem[r_rdPtr];
  assign o_count  = r_count;

  // Storage array carries no reset; only the pointers define what is live
  always_ff @(posedge i_clk) begin
    if (w_doPush && !i_reset && !i_flush) r_mem[r_wrPtr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      if (w_doPush && !w_doPop)      r_count <= r_count + CNT_W'(1);
      else if (!w_doPush && w_doPop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cvp_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word read per cycle to
// a fixed-latency instruction memory, tracks reads in flight in a shift pipe,
// queues returned words and presents them to the decoder over valid/ready.
// Redirect restarts fetch at a new address and squashes reads in flight.
module cvp_fetch_unit
  import cvp_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INST_W  = DEF_INST_W,
  parameter int MEM_LAT = 1,
  parameter int DEPTH   = 2
) (
  input  logic              Clk1,
  input  logic              Reset,
  output logic [ADDR_W-1:0] Addr,
  output logic              RD,
  input  logic [INST_W-1:0] DataIn,
  output logic [INST_W-1:0] InstOut,
  output logic [ADDR_W-1:0] InstPC,
  output logic              InstValid,
  input  logic              InstReady,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INF_W = $clog2(MEM_LAT + 1);
  localparam int ENT_W = INST_W + ADDR_W;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_rd;
  logic [MEM_LAT-1:0] r_pipeValid;
  logic [ADDR_W-1:0]  r_pipeAddr [MEM_LAT];

  logic [CNT_W-1:0]   w_count;
  logic               w_empty;
  logic [ENT_W-1:0]   w_head;
  logic               w_pop;
  logic               w_return;
  logic               w_issue;
  logic [INF_W-1:0]   w_inflight;

  assign Addr      = r_addr;
  assign RD        = r_rd;
  assign InstValid = ~w_empty;
  assign InstOut   = w_head[ENT_W-1:ADDR_W];
  assign InstPC    = w_head[ADDR_W-1:0];
  assign w_pop     = ~w_empty & InstReady;
  assign w_return  = r_pipeValid[MEM_LAT-1];

  // Count reads in flight so queue space is reserved before a word returns
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) w_inflight = w_inflight + INF_W'(r_pipeValid[i]);
  end

  // A pop this cycle frees a slot, so it is credited before deciding to issue
  assign w_issue = (32'(w_count) + 32'(w_inflight) - 32'(w_pop)) < 32'(DEPTH);

  cvp_inst_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENT_W)
  ) u_fifo (
    .i_clk   (Clk1),
    .i_reset (Reset),
    .i_flush (Redirect),
    .i_push  (w_return),
    .i_pop   (w_pop),
    .i_data  ({DataIn, r_pipeAddr[MEM_LAT-1]}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // PC, read strobe and in-flight pipe; reset beats redirect beats issue
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      r_pc        <= '0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_pipeValid <= '0;
      for (int i = 0; i < MEM_LAT; i++) r_pipeAddr[i] <= '0;
    end else if (Redirect) begin
      r_addr         <= RedirectPC;
      r_rd           <= 1'b1;
      r_pc           <= RedirectPC + ADDR_W'(1);
      r_pipeValid    <= '0;
      r_pipeValid[0] <= 1'b1;
      r_pipeAddr[0]  <= RedirectPC;
    end else begin
      for (int i = MEM_LAT - 1; i >= 1; i--) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeAddr[i]  <= r_pipeAddr[i-1];
      end
      r_pipeValid[0] <= w_issue;
      if (w_issue) begin
        r_addr        <= r_pc;
        r_rd          <= 1'b1;
        r_pc          <= r_pc + ADDR_W'(1);
        r_pipeAddr[0] <= r_pc;
      end else begin
        r_rd <= 1'b0;
      end
    end
  end

endmodule
